note_player: RTL and testbench
==============================

# note_player

Consumer of the divided-clock tick strobe. It accepts one note at a time over a valid/ready handshake and drives a square wave on the speaker pin at the note's pitch. The note lasts a number of tick periods, followed by a one-tick silent release, and then a `done` pulse. It sits between the song/keyboard front-end and the buzzer pin, with its time base supplied by the tick divider.

## Interface

- `CLK_HZ`, default 100_000_000: `clk` frequency, used to build the pitch table.
- `HALF_W`, default 18: width of the half-period counter; must hold the largest table entry.
- `DUR_W`, default 16: width of `note_dur`.
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `tick`, input, 1: one-cycle duration strobe from the tick divider; must be high for at most one cycle per period.
- `note_valid`, input, 1: a note is offered.
- `note_ready`, output, 1: the block can accept a note.
- `note_code`, input, 5: 0 = rest; 1..21 = C4, D4, E4, F4, G4, A4, B4, C5 … B6 (three natural-note octaves); 22..31 play as a rest.
- `note_dur`, input, DUR_W: note length in tick periods.
- `abort`, input, 1: synchronous stop.
- `speaker`, output, 1: square-wave output.
- `busy`, output, 1: high in PLAY or RELEASE.
- `done`, output, 1: one-cycle pulse when a note completes normally.

## Operation

- States: IDLE, PLAY, RELEASE. All outputs are registered.
- **Reset** (asynchronous): state IDLE; counters 0; `speaker`=0, `busy`=0, `done`=0, `note_ready`=0. `note_ready` rises on the first clock edge after `rst_n` deasserts.
- **IDLE**:
  - `note_ready`=1.
  - On an edge where `note_valid & note_ready & ~abort`: capture `note_code` and `note_dur`, clear the half-period counter, clear the tick counter, set `speaker`=0, and go to PLAY.
  - `note_ready` drops on the same edge.
- **PLAY**:
  - Half-period counter increments each cycle. When it equals `HALF[code]-1`, it wraps to 0 and `speaker` toggles.
  - For a rest or invalid code, `speaker` is held at 0 and the counter is idle.
  - Each `tick` increments the tick counter. On the tick that makes the count equal `note_dur`, go to RELEASE and force `speaker`=0.
- **Zero duration**: `note_dur`=0 goes from PLAY to RELEASE one cycle after acceptance, with no toggles.
- **RELEASE**: `speaker`=0. On the next `tick`, pulse `done` for one cycle and return to IDLE; `note_ready`=1 on that same edge.
- **Pitch table**: `HALF[n]` = round(CLK_HZ / (2·f_n)), equal temperament with A4 = 440 Hz. At 100 MHz: C4 = 191113, A4 = 113636, C5 = 95556, B6 = 25310. The table is a constant function of `CLK_HZ`.
- **Abort**:
  - In any state, `abort`=1 forces IDLE on the next edge: `speaker`=0, `busy`=0, no `done`, counters cleared.
  - Abort together with `note_valid` in IDLE means no accept.
- **Input stability**: `note_code` and `note_dur` changes after acceptance have no effect.
- **Tick counter width**: DUR_W bits. It never wraps, because the exit compare happens before overflow.

## Timing

- Accept edge to first `speaker` rise: `HALF[code]` cycles.
- Audible length: between `note_dur-1` and `note_dur` tick periods, depending on tick phase at accept.
- Release: time from the ending tick to the next tick (one period), then `done`.
- `done` and `note_ready` rise on the same edge. A new note can be accepted on the following edge, which gives back-to-back throughput.
- A `tick` coinciding with the accept edge is not counted.

## Test plan

- Reset mid-PLAY (A4, dur 5): `rst_n` low asynchronously → `speaker`/`busy`/`done` go 0 immediately; `note_ready`=1 one edge after release.
- A4, dur 3, tick every 1000 cycles: `speaker` period 227272 cycles (first rise 113636 cycles after accept); three ticks → RELEASE; next tick → one-cycle `done`.
- Rest (code 0) and code 25, dur 2 → `speaker` stays 0 throughout, `busy`=1, `done` after the 3rd tick.
- `note_dur`=0, C4 → no `speaker` toggle; `done` on the first tick after acceptance.
- `abort` asserted in PLAY and in RELEASE → IDLE next edge, no `done`. `abort` + `note_valid` in IDLE → not accepted.
- Back-to-back: `note_valid` held high with B6 then C5 → second note accepted on the edge after `done`, with no lost or duplicated handshake.

Source files
------------

// File: rtl/note_player_if.sv
// Note handshake bundle between the song/keyboard front-end (master) and
// note_player (slave).
interface note_player_if #(
    parameter int DUR_W = 16
);
    logic             note_valid;
    logic             note_ready;
    logic [4:0]       note_code;
    logic [DUR_W-1:0] note_dur;

    modport master (
        output note_valid,
        output note_code,
        output note_dur,
        input  note_ready
    );

    modport slave (
        input  note_valid,
        input  note_code,
        input  note_dur,
        output note_ready
    );
endinterface

// File: rtl/note_player.sv
// Plays one note at a time as a square wave on the speaker pin.
// The note lasts note_dur tick periods, then a one-tick silent release, then done.
module note_player #(
    parameter int CLK_HZ = 100_000_000,
    parameter int HALF_W = 18,
    parameter int DUR_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          abort,
    note_player_if.slave  note,
    output logic          speaker,
    output logic          busy,
    output logic          done
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Equal-tempered natural notes C4..B6 in micro-hertz, A4 = 440 Hz.
    function automatic longint unsigned note_freq_uhz(input int code);
        case (code)
            1:       return 64'd261625565;
            2:       return 64'd293664768;
            3:       return 64'd329627557;
            4:       return 64'd349228231;
            5:       return 64'd391995436;
            6:       return 64'd440000000;
            7:       return 64'd493883301;
            8:       return 64'd523251131;
            9:       return 64'd587329536;
            10:      return 64'd659255114;
            11:      return 64'd698456463;
            12:      return 64'd783990872;
            13:      return 64'd880000000;
            14:      return 64'd987766603;
            15:      return 64'd1046502261;
            16:      return 64'd1174659072;
            17:      return 64'd1318510228;
            18:      return 64'd1396912926;
            19:      return 64'd1567981744;
            20:      return 64'd1760000000;
            21:      return 64'd1975533205;
            default: return 64'd0;
        endcase
    endfunction

    // Rounded half period in clk cycles; zero marks a rest.
    function automatic logic [HALF_W-1:0] half_period(input int code);
        longint unsigned den;
        longint unsigned num;
        longint unsigned q;
        den = 64'd2 * note_freq_uhz(code);
        num = 64'(CLK_HZ) * 64'd1_000_000;
        if (den == 64'd0) begin
            q = 64'd0;
        end else begin
            q = (num + den / 64'd2) / den;
        end
        return HALF_W'(q);
    endfunction

    logic [HALF_W-1:0] half_rom [32];

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_pitch
            localparam logic [HALF_W-1:0] HALF_VAL = half_period(gi);
            assign half_rom[gi] = HALF_VAL;
        end
    endgenerate

    logic [1:0]        state_reg;
    logic              tone_reg;
    logic [HALF_W-1:0] half_m1_reg;
    logic [HALF_W-1:0] half_cnt_reg;
    logic [DUR_W-1:0]  dur_reg;
    logic [DUR_W-1:0]  tick_cnt_reg;
    logic              speaker_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              ready_reg;

    logic              accept;
    logic              code_is_tone;
    logic              last_tick;

    assign code_is_tone = (note.note_code >= 5'd1) && (note.note_code <= 5'd21);
    assign accept       = note.note_valid && ready_reg;
    // Compare one wider so the count can reach all-ones durations without wrapping.
    assign last_tick    = ({1'b0, tick_cnt_reg} + (DUR_W+1)'(1)) == {1'b0, dur_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            tone_reg     <= 1'b0;
            half_m1_reg  <= '0;
            half_cnt_reg <= '0;
            dur_reg      <= '0;
            tick_cnt_reg <= '0;
            speaker_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            ready_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (abort) begin
                state_reg    <= ST_IDLE;
                half_cnt_reg <= '0;
                tick_cnt_reg <= '0;
                speaker_reg  <= 1'b0;
                busy_reg     <= 1'b0;
                ready_reg    <= 1'b1;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        ready_reg <= 1'b1;
                        if (accept) begin
                            tone_reg     <= code_is_tone;
                            half_m1_reg  <= half_rom[note.note_code] - HALF_W'(1);
                            dur_reg      <= note.note_dur;
                            half_cnt_reg <= '0;
                            tick_cnt_reg <= '0;
                            speaker_reg  <= 1'b0;
                            busy_reg     <= 1'b1;
                            ready_reg    <= 1'b0;
                            state_reg    <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if ((dur_reg == '0) || (tick && last_tick)) begin
                            speaker_reg  <= 1'b0;
                            half_cnt_reg <= '0;
                            state_reg    <= ST_RELEASE;
                        end else begin
                            if (tick) begin
                                tick_cnt_reg <= tick_cnt_reg + DUR_W'(1);
                            end
                            if (tone_reg) begin
                                if (half_cnt_reg == half_m1_reg) begin
                                    half_cnt_reg <= '0;
                                    speaker_reg  <= ~speaker_reg;
                                end else begin
                                    half_cnt_reg <= half_cnt_reg + HALF_W'(1);
                                end
                            end
                        end
                    end
                    ST_RELEASE: begin
                        speaker_reg <= 1'b0;
                        if (tick) begin
                            done_reg     <= 1'b1;
                            busy_reg     <= 1'b0;
                            ready_reg    <= 1'b1;
                            tick_cnt_reg <= '0;
                            state_reg    <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_reg   <= ST_IDLE;
                        speaker_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                        ready_reg   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign note.note_ready = ready_reg;
    assign speaker         = speaker_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;
endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player at CLK_HZ = 1 MHz so pitch periods stay short:
// half periods C4 = 1911, A4 = 1136, C5 = 956, B6 = 253 cycles.
module tb_note_player;
    localparam int DUR_W = 16;

    logic clk;
    logic rst_n;
    logic tick;
    logic abort;
    logic speaker;
    logic busy;
    logic done;

    note_player_if #(.DUR_W(DUR_W)) nif ();

    note_player #(
        .CLK_HZ(1_000_000),
        .HALF_W(18),
        .DUR_W (DUR_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .abort  (abort),
        .note   (nif),
        .speaker(speaker),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int rel     = 0;
    int tick_p  = 100;
    bit tick_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // One clock; tick is raised for the edge that lands on a multiple of tick_p.
    task automatic cycle();
        tick = tick_en && (((rel + 1) % tick_p) == 0);
        @(posedge clk);
        #1;
        rel++;
        tick = 1'b0;
    endtask

    task automatic do_accept(input logic [4:0] code, input logic [DUR_W-1:0] dur, input logic acc_tick);
        nif.note_code  = code;
        nif.note_dur   = dur;
        nif.note_valid = 1'b1;
        check("ready_before_accept", 32'(nif.note_ready), 32'd1);
        tick = acc_tick;
        @(posedge clk);
        #1;
        tick = 1'b0;
        rel = 0;
        nif.note_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("ready_after_accept", 32'(nif.note_ready), 32'd0);
        // Later input changes must not affect the note in flight.
        nif.note_code = 5'd3;
        nif.note_dur  = '1;
    endtask

    task automatic play(input string name, input logic [4:0] code, input logic [DUR_W-1:0] dur,
                        input int p, input logic acc_tick, input int exp_toggles,
                        input int exp_rise, input int exp_last, input int exp_done);
        int toggles;
        int rise;
        int last;
        int done_rel;
        int busy_drop;
        logic prev;
        tick_p = p;
        tick_en = 1'b1;
        do_accept(code, dur, acc_tick);
        toggles = 0; rise = -1; last = -1; done_rel = -1; busy_drop = 0;
        prev = speaker;
        while (done_rel < 0 && rel < exp_done + 2000) begin
            cycle();
            if (speaker !== prev) begin
                toggles++;
                last = rel;
                if (speaker === 1'b1 && rise < 0) rise = rel;
            end
            prev = speaker;
            if (done === 1'b1) begin
                done_rel = rel;
                check({name, "_busy_at_done"}, 32'(busy), 32'd0);
                check({name, "_ready_at_done"}, 32'(nif.note_ready), 32'd1);
            end else if (busy !== 1'b1) begin
                busy_drop = 1;
            end
        end
        check({name, "_done_cycle"}, 32'(done_rel), 32'(exp_done));
        check({name, "_toggles"}, 32'(toggles), 32'(exp_toggles));
        check({name, "_first_rise"}, 32'(rise), 32'(exp_rise));
        check({name, "_last_toggle"}, 32'(last), 32'(exp_last));
        check({name, "_busy_held"}, 32'(busy_drop), 32'd0);
        cycle();
        check({name, "_done_one_cycle"}, 32'(done), 32'd0);
        tick_en = 1'b0;
        $display("[TB] note %s code=%0d dur=%0d done at cycle %0d toggles %0d", name, code, dur, done_rel, toggles);
    endtask

    initial begin
        int done_seen;
        int busy_seen;
        int hs;
        int done_cnt;
        int first_done;
        int last_done;
        int second_acc;
        int rise;
        logic hs_now;

        rst_n = 1'b0;
        tick = 1'b0;
        abort = 1'b0;
        nif.note_valid = 1'b0;
        nif.note_code = '0;
        nif.note_dur = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_speaker", 32'(speaker), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(nif.note_ready), 32'd0);
        rst_n = 1'b1;
        check("ready_low_before_edge", 32'(nif.note_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_first_edge", 32'(nif.note_ready), 32'd1);
        $display("[TB] reset released, note_ready up");

        // Asynchronous reset in the middle of an A4 note
        tick_p = 100;
        tick_en = 1'b1;
        do_accept(5'd6, 16'd5, 1'b0);
        repeat (50) cycle();
        check("midplay_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_speaker", 32'(speaker), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_ready", 32'(nif.note_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick_en = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rerst", 32'(nif.note_ready), 32'd1);
        $display("[TB] mid-play reset done");

        // name, code, dur, tick period, tick on accept, toggles, first rise, last toggle, done
        play("a4_dur3",   5'd6,  16'd3, 1000, 1'b0, 2, 1136, 2272, 4000);
        play("rest_dur2", 5'd0,  16'd2, 100,  1'b1, 0, -1,   -1,   300);
        play("code25",    5'd25, 16'd2, 100,  1'b0, 0, -1,   -1,   300);
        play("c4_dur0",   5'd1,  16'd0, 100,  1'b0, 0, -1,   -1,   100);

        // Abort while the speaker is high in PLAY
        tick_p = 1000;
        tick_en = 1'b1;
        do_accept(5'd6, 16'd3, 1'b0);
        while (rel < 1500) cycle();
        check("abort_play_speaker_pre", 32'(speaker), 32'd1);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("abort_play_speaker", 32'(speaker), 32'd0);
        check("abort_play_busy", 32'(busy), 32'd0);
        check("abort_play_ready", 32'(nif.note_ready), 32'd1);
        done_seen = 0; busy_seen = 0;
        while (rel < 4500) begin
            cycle();
            if (done === 1'b1) done_seen = 1;
            if (busy === 1'b1 || speaker === 1'b1) busy_seen = 1;
        end
        check("abort_play_no_done", 32'(done_seen), 32'd0);
        check("abort_play_stays_idle", 32'(busy_seen), 32'd0);
        $display("[TB] abort in PLAY at cycle 1500");

        // Abort in RELEASE (C4, one tick)
        tick_p = 100;
        do_accept(5'd1, 16'd1, 1'b0);
        while (rel < 150) cycle();
        check("release_busy_pre", 32'(busy), 32'd1);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("abort_rel_busy", 32'(busy), 32'd0);
        check("abort_rel_ready", 32'(nif.note_ready), 32'd1);
        done_seen = 0;
        while (rel < 450) begin
            cycle();
            if (done === 1'b1) done_seen = 1;
        end
        check("abort_rel_no_done", 32'(done_seen), 32'd0);
        tick_en = 1'b0;
        $display("[TB] abort in RELEASE at cycle 150");

        // Abort together with note_valid in IDLE
        nif.note_code = 5'd6;
        nif.note_dur = 16'd1;
        nif.note_valid = 1'b1;
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        nif.note_valid = 1'b0;
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_idle_ready", 32'(nif.note_ready), 32'd1);
        cycle();
        check("abort_idle_busy_later", 32'(busy), 32'd0);
        $display("[TB] abort with valid in IDLE");

        // Back-to-back: valid held high, B6 dur 3 then C5 dur 1
        tick_p = 100;
        tick_en = 1'b1;
        nif.note_code = 5'd21;
        nif.note_dur = 16'd3;
        nif.note_valid = 1'b1;
        check("b2b_ready_first", 32'(nif.note_ready), 32'd1);
        @(posedge clk);
        #1;
        rel = 0;
        hs = 1;
        nif.note_code = 5'd8;
        nif.note_dur = 16'd1;
        done_cnt = 0; first_done = -1; last_done = -1; second_acc = -1; rise = -1;
        while (rel < 700) begin
            hs_now = nif.note_valid && nif.note_ready;
            cycle();
            if (hs_now) begin
                hs++;
                if (second_acc < 0) second_acc = rel;
                nif.note_valid = 1'b0;
            end
            if (speaker === 1'b1 && rise < 0) rise = rel;
            if (done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = rel;
                last_done = rel;
            end
        end
        nif.note_valid = 1'b0;
        tick_en = 1'b0;
        check("b2b_b6_rise", 32'(rise), 32'd253);
        check("b2b_first_done", 32'(first_done), 32'd400);
        check("b2b_second_accept", 32'(second_acc), 32'd401);
        check("b2b_second_done", 32'(last_done), 32'd600);
        check("b2b_handshakes", 32'(hs), 32'd2);
        check("b2b_done_count", 32'(done_cnt), 32'd2);
        $display("[TB] back-to-back B6 then C5: accepts %0d, dones %0d", hs, done_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
